lstm_weight_loader: RTL and testbench

- Write-side counterpart of the LSTM weight store.
- Accepts a host byte stream (valid/ready) and assembles 16-bit weights as low byte then high byte.
- Writes the low byte to bank w0 and the high byte to bank w1 at a sequential word address, so the read side returns {w1,w0}.
- Sits between the host link (SPI/UART deframer) and the two 8-bit weight RAMs; also reports a running checksum for host-side validation.

---
 rtl/lstm_weight_loader.sv | 116 +++++++++++
 tb/tb_lstm_weight_loader.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_weight_loader.sv
// Write-side loader for the LSTM weight store: assembles 16-bit weights from a
// byte stream (low byte first) and writes them to two 8-bit banks at sequential addresses.
module lstm_weight_loader #(
  parameter int col    = 512,
  parameter int cow    = 96,
  parameter int QZ     = 16,
  parameter int LEN    = col*cow*4 + col*col*5,
  parameter int ADDR_W = $clog2(LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [QZ/2-1:0]   s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [QZ/2-1:0]   wr_data0,
  output logic [QZ/2-1:0]   wr_data1,
  output logic              busy,
  output logic              done,
  output logic [QZ-1:0]     checksum
);

  localparam int BW = QZ/2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN-1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [BW-1:0]     r_low;
  logic              r_wrEn;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [BW-1:0]     r_wrData0;
  logic [BW-1:0]     r_wrData1;
  logic [QZ-1:0]     r_checksum;

  logic w_xfer;
  logic w_loXfer;
  logic w_hiXfer;
  logic w_restart;

  assign w_xfer    = s_valid && s_ready;
  assign w_loXfer  = w_xfer && (r_state == LO) && !abort;
  assign w_hiXfer  = w_xfer && (r_state == HI) && !abort;
  assign w_restart = start && !abort && ((r_state == IDLE) || (r_state == DONE));

  assign s_ready  = (r_state == LO) || (r_state == HI);
  assign busy     = (r_state == LO) || (r_state == HI);
  assign done     = (r_state == DONE);
  assign wr_en    = r_wrEn;
  assign wr_addr  = r_wrAddr;
  assign wr_data0 = r_wrData0;
  assign wr_data1 = r_wrData1;
  assign checksum = r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // abort outranks start and any transfer in the same cycle
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next = LO;
        LO:      if (w_xfer) w_next = HI;
        HI:      if (w_xfer) w_next = (r_addr == LAST_ADDR) ? DONE : LO;
        DONE:    if (start) w_next = LO;
        default: w_next = IDLE;
      endcase
    end
  end

  // Write port outputs hold their last values between strobes; the address
  // counter parks at the final word instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_low      <= '0;
      r_wrEn     <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData0  <= '0;
      r_wrData1  <= '0;
      r_checksum <= '0;
    end else begin
      r_wrEn <= w_hiXfer;
      if (abort) begin
        r_low <= '0;
      end else if (w_restart) begin
        r_addr     <= '0;
        r_checksum <= '0;
      end else if (w_loXfer) begin
        r_low <= s_data;
      end else if (w_hiXfer) begin
        r_wrAddr   <= r_addr;
        r_wrData0  <= r_low;
        r_wrData1  <= s_data;
        r_checksum <= r_checksum + {s_data, r_low};
        if (r_addr != LAST_ADDR) begin
          r_addr <= r_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lstm_weight_loader.sv
// Randomized self-checking bench for lstm_weight_loader with a word-level
// reference model (expected write list and running checksum).
module tb_lstm_weight_loader;

  localparam int COL = 2;
  localparam int COW = 1;
  localparam int QZ  = 16;
  localparam int LEN = COL*COW*4 + COL*COL*5;
  localparam int AW  = $clog2(LEN);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data0;
  logic [7:0]    wr_data1;
  logic          busy;
  logic          done;
  logic [15:0]   checksum;

  lstm_weight_loader #(.col(COL), .cow(COW), .QZ(QZ)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int addr; int d0; int d1;} wr_t;

  int  cyc = 0;
  wr_t obsQ[$];
  wr_t expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  modelAddr = 0;
  int  modelSum = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive log of every write strobe, stamped with the cycle it appeared in
  always @(negedge clk) begin
    if (wr_en === 1'b1) obsQ.push_back('{cyc, int'(wr_addr), int'(wr_data0), int'(wr_data1)});
  end

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sendByte_timeout: s_ready=%b, required 1", s_ready);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic modelWord(input logic [7:0] lo, input logic [7:0] hi);
    expQ.push_back('{cyc, modelAddr, int'(lo), int'(hi)});
    modelSum = (modelSum + int'(hi) * 256 + int'(lo)) % 65536;
    modelAddr++;
  endtask

  task automatic sendWord(input logic [7:0] lo, input logic [7:0] hi);
    sendByte(lo);
    sendByte(hi);
    modelWord(lo, hi);
  endtask

  task automatic doStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    modelAddr = 0;
    modelSum  = 0;
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic doAbort();
    s_valid = 1'b0;
    abort   = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, wr_en, busy, done} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: {s_ready,wr_en,busy,done}=%b, required 0000", {s_ready, wr_en, busy, done});
    end
    checks++;
    if ({wr_addr, wr_data0, wr_data1} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_wr: addr=%0d d0=%h d1=%h, required all 0", wr_addr, wr_data0, wr_data1);
    end
    checks++;
    if (checksum !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_checksum: %h, required 0000", checksum);
    end
    s_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    doStart();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_after_reset: s_ready=%b busy=%b, required 1 1", s_ready, busy);
    end
  endtask

  task automatic test_full_load();
    int n;
    for (int k = 0; k < LEN; k++) sendWord(8'(2*k+1), 8'(2*k+2));
    idle(2);
    checks++;
    if (obsQ.size() != LEN) begin
      errors++;
      $display("[TB] FAIL full_count: %0d writes, required %0d", obsQ.size(), LEN);
    end
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obsQ[i].addr !== expQ[i].addr || obsQ[i].d0 !== expQ[i].d0 ||
          obsQ[i].d1 !== expQ[i].d1 || obsQ[i].cyc !== expQ[i].cyc) begin
        errors++;
        $display("[TB] FAIL full_write%0d: addr=%0d d0=%h d1=%h cyc=%0d, required addr=%0d d0=%h d1=%h cyc=%0d",
                 i, obsQ[i].addr, obsQ[i].d0, obsQ[i].d1, obsQ[i].cyc,
                 expQ[i].addr, expQ[i].d0, expQ[i].d1, expQ[i].cyc);
      end
    end
    checks++;
    if (done !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_done: done=%b s_ready=%b busy=%b, required 1 0 0", done, s_ready, busy);
    end
    checks++;
    if (checksum !== 16'(modelSum)) begin
      errors++;
      $display("[TB] FAIL full_checksum: %h, required %h", checksum, 16'(modelSum));
    end
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== AW'(LEN-1) || wr_data1 !== 8'h38) begin
      errors++;
      $display("[TB] FAIL full_hold: wr_en=%b addr=%0d d1=%h, required 0 %0d 38", wr_en, wr_addr, wr_data1, LEN-1);
    end
    s_valid = 1'b1;
    s_data  = 8'h77;
    repeat (4) @(posedge clk);
    #1;
    s_valid = 1'b0;
    checks++;
    if (obsQ.size() != LEN || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_park: writes=%0d done=%b, required %0d 1", obsQ.size(), done, LEN);
    end
  endtask

  task automatic test_stall();
    int n0;
    doStart();
    checks++;
    if (checksum !== 16'h0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_clear: checksum=%h done=%b, required 0000 0", checksum, done);
    end
    for (int k = 0; k < 2; k++) sendWord(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    sendByte(8'hAA);
    s_valid = 1'b0;
    @(negedge clk);
    n0 = obsQ.size();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (obsQ.size() != n0) begin
      errors++;
      $display("[TB] FAIL stall_quiet: %0d writes during stall, required 0", obsQ.size() - n0);
    end
    sendByte(8'h55);
    modelWord(8'hAA, 8'h55);
    idle(2);
    checks++;
    if (obsQ.size() != 3 || expQ.size() != 3) begin
      errors++;
      $display("[TB] FAIL stall_count: %0d writes, required 3", obsQ.size());
    end else if (obsQ[2].d0 !== 8'hAA || obsQ[2].d1 !== 8'h55 || obsQ[2].addr !== 2 || obsQ[2].cyc !== expQ[2].cyc) begin
      errors++;
      $display("[TB] FAIL stall_write: addr=%0d d0=%h d1=%h cyc=%0d, required 2 aa 55 %0d",
               obsQ[2].addr, obsQ[2].d0, obsQ[2].d1, obsQ[2].cyc, expQ[2].cyc);
    end
    checks++;
    if (checksum !== 16'(modelSum)) begin
      errors++;
      $display("[TB] FAIL stall_checksum: %h, required %h", checksum, 16'(modelSum));
    end
  endtask

  task automatic test_abort();
    int n0;
    int sumBefore;
    logic [7:0] lo;
    logic [7:0] hi;
    sendWord(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    sendByte(8'($urandom_range(0, 255)));
    sumBefore = modelSum;
    hi = 8'($urandom_range(0, 255));
    s_valid = 1'b1;
    s_data  = hi;
    abort   = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    n0 = obsQ.size();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n0 != expQ.size() || obsQ.size() != n0) begin
      errors++;
      $display("[TB] FAIL abort_strobe: writes=%0d, required %0d", obsQ.size(), expQ.size());
    end
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_state: busy=%b s_ready=%b done=%b, required 0 0 0", busy, s_ready, done);
    end
    checks++;
    if (checksum !== 16'(sumBefore)) begin
      errors++;
      $display("[TB] FAIL abort_checksum: %h, required %h", checksum, 16'(sumBefore));
    end
    doStart();
    checks++;
    if (checksum !== 16'h0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_restart: checksum=%h busy=%b, required 0000 1", checksum, busy);
    end
    lo = 8'($urandom_range(0, 255));
    hi = 8'($urandom_range(0, 255));
    sendWord(lo, hi);
    sendWord(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    idle(2);
    checks++;
    if (obsQ.size() != 2) begin
      errors++;
      $display("[TB] FAIL abort_rewrite_count: %0d, required 2", obsQ.size());
    end else if (obsQ[0].addr !== 0 || obsQ[1].addr !== 1 || obsQ[0].d0 !== int'(lo) || obsQ[0].d1 !== int'(hi)) begin
      errors++;
      $display("[TB] FAIL abort_rewrite: addr0=%0d addr1=%0d d0=%h d1=%h, required 0 1 %h %h",
               obsQ[0].addr, obsQ[1].addr, obsQ[0].d0, obsQ[0].d1, lo, hi);
    end
    checks++;
    if (checksum !== 16'(modelSum)) begin
      errors++;
      $display("[TB] FAIL abort_rewrite_checksum: %h, required %h", checksum, 16'(modelSum));
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    doAbort();
    doStart();
    for (int k = 0; k < LEN; k++) begin
      if (k == 10) start = 1'b1;
      sendWord(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      start = 1'b0;
    end
    idle(2);
    checks++;
    if (obsQ.size() != LEN) begin
      errors++;
      $display("[TB] FAIL busy_start_count: %0d writes, required %0d", obsQ.size(), LEN);
    end
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obsQ[i].addr !== expQ[i].addr || obsQ[i].d0 !== expQ[i].d0 || obsQ[i].d1 !== expQ[i].d1) begin
        errors++;
        $display("[TB] FAIL busy_start_write%0d: addr=%0d d0=%h d1=%h, required addr=%0d d0=%h d1=%h",
                 i, obsQ[i].addr, obsQ[i].d0, obsQ[i].d1, expQ[i].addr, expQ[i].d0, expQ[i].d1);
      end
    end
    checks++;
    if (done !== 1'b1 || checksum !== 16'(modelSum)) begin
      errors++;
      $display("[TB] FAIL busy_start_done: done=%b checksum=%h, required 1 %h", done, checksum, 16'(modelSum));
    end
    doStart();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || checksum !== 16'h0) begin
      errors++;
      $display("[TB] FAIL done_restart: done=%b busy=%b checksum=%h, required 0 1 0000", done, busy, checksum);
    end
    sendWord(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    idle(2);
    checks++;
    if (obsQ.size() != 1 || obsQ[0].addr !== 0) begin
      errors++;
      $display("[TB] FAIL done_restart_addr: writes=%0d, required one write at addr 0", obsQ.size());
    end
  endtask

  task automatic test_checksum_wrap();
    doAbort();
    doStart();
    sendWord(8'hFF, 8'hFF);
    sendWord(8'h02, 8'h00);
    idle(2);
    checks++;
    if (checksum !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL checksum_wrap: %h, required 0001", checksum);
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] lo;
    logic [7:0] hi;
    doAbort();
    doStart();
    for (int k = 0; k < 3; k++) sendWord(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    sendByte(8'($urandom_range(0, 255)));
    s_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({s_ready, wr_en, busy, done} !== 4'b0000 || checksum !== 16'h0 || {wr_addr, wr_data0, wr_data1} !== '0) begin
      errors++;
      $display("[TB] FAIL midload_reset: ready=%b busy=%b addr=%0d checksum=%h, required all 0",
               s_ready, busy, wr_addr, checksum);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    doStart();
    lo = 8'($urandom_range(0, 255));
    hi = 8'($urandom_range(0, 255));
    sendWord(lo, hi);
    idle(2);
    checks++;
    if (obsQ.size() != 1 || obsQ[0].addr !== 0 || obsQ[0].d0 !== int'(lo) || obsQ[0].d1 !== int'(hi) ||
        checksum !== {hi, lo}) begin
      errors++;
      $display("[TB] FAIL midload_restart: writes=%0d checksum=%h, required 1 write at addr 0 and %h",
               obsQ.size(), checksum, {hi, lo});
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_abort();
    test_start_while_busy();
    test_checksum_wrap();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
